mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Memory bus controller and arbiter between the instruction-fetch path and the decode unit's data-access path (memory_read_state / memory_write_state) of the Z80-style core. It selects the data address from the PC, register-file or immediate source, and arbitrates so that only one access is on the external byte-wide memory port at a time. It runs the external ready handshake with a bounded wait-state count, then returns read data and a one-cycle completion pulse to the requester.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
MAX_WAIT, 15, maximum wait cycles for mem_ready before abort (≥1); counter width $clog2(MAX_WAIT+1)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
fetch_req  in  1  fetch request, level, held until fetch_done/err
pc_addr  in  ADDR_W  PC value for fetch and value_from_pc data accesses
data_req  in  1  data request, level, held until data_done/err
data_we  in  1  1 = write, 0 = read
data_src  in  2  cu_pkg::mem_req_source_sel, address source for data access
reg_addr  in  ADDR_W  register-file address (HL/BC/DE/SP path)
imm_addr  in  ADDR_W  immediate address
data_wdata  in  DATA_W  write data
rdata  out  DATA_W  latched read data, valid with *_done
fetch_done  out  1  one-cycle pulse, fetch complete
data_done  out  1  one-cycle pulse, data access complete
bus_err  out  1  one-cycle pulse: timeout or illegal data_src
busy  out  1  access in flight (state != IDLE)
mem_addr  out  ADDR_W  external address, registered
mem_wdata  out  DATA_W  external write data, registered
mem_re  out  1  external read strobe
mem_we  out  1  external write strobe
mem_ready  in  1  external access complete

Behaviour:
- Reset (async): state=IDLE; all outputs 0; wait counter 0; last_grant=DATA. All strobes drop immediately on rst, even mid-access; the aborted access produces no done or error pulse.
- States: IDLE, ACCESS, COMPLETE.
- IDLE: sample requests.
  - Only one request pending: grant it.
  - Both pending: grant the one not granted last (alternate), so neither side starves.
  - On grant: register mem_addr, mem_wdata, direction and owner; go to ACCESS next cycle. A fetch always reads from pc_addr.
  - Data address select: value_from_pc → pc_addr, value_from_reg_file → reg_addr, value_from_imm → imm_addr.
  - data_src=2'b11 with data granted: no bus access; bus_err pulses the next cycle; stay IDLE; last_grant updates.
- ACCESS: mem_re (read) or mem_we (write) held high, with address and data stable.
  - mem_ready=1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged); go to COMPLETE.
  - mem_ready=0: increment wait counter. If mem_ready is still 0 after MAX_WAIT wait cycles (MAX_WAIT+1 ACCESS cycles in total), drop the strobe, pulse bus_err, and return to IDLE with no done pulse.
- COMPLETE: strobes low; pulse fetch_done or data_done for the granted owner; clear the counter; return to IDLE.
  - Requester drops req the same cycle it sees done, so there is no re-grant, because IDLE samples only on the following cycle.
- Latency: grant in cycle N, strobe in N+1; with mem_ready=1 in N+1, done and rdata appear in N+2. Back-to-back accesses take 3 cycles each.
- Request deasserted mid-access: the access still completes and done still pulses; the requester ignores it.
- Requests are only sampled in IDLE; inputs changing during ACCESS have no effect on the in-flight access.
- mem_re and mem_we are never both 1. busy = (state != IDLE).

Decomposition:
- cu_pkg already provides mem_req_source_sel; use it for data_src.
- Add to cu_pkg:
  - typedef enum bus_state {bus_idle, bus_access, bus_complete}
  - typedef enum bus_owner {owner_fetch, owner_data}
- No sub-module needed; address-select mux is an inline function in the package (addr_from_source).

Test Plan:
- Fetch only: pc_addr=16'h0100, fetch_req=1, mem_ready=1 immediately with mem_rdata=8'h3E → mem_re with mem_addr=0100 for 1 cycle; fetch_done and rdata=3E exactly 2 cycles after grant.
- Data write, src=value_from_reg_file, reg_addr=16'hC000, wdata=8'h55, mem_ready after 3 waits → mem_we held 4 cycles at C000/55, then data_done; rdata unchanged.
- Simultaneous fetch_req and data_req held continuously (last_grant=DATA after reset) → grant order fetch, data, fetch, data; each access takes 3 cycles with mem_ready=1.
- Timeout, MAX_WAIT=15, mem_ready stuck 0 → strobe high 16 cycles, then bus_err pulse, no done; next request serviced normally.
- data_src=2'b11 → no strobe, bus_err 1 cycle later; src=value_from_imm, imm_addr=16'h8000 → mem_addr=8000.
- rst asserted mid-ACCESS → mem_re, mem_we, busy low in the same cycle (async); no done or err after rst is released.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared control-unit types for the core.
//   mem_req_source_sel : address source for decode-unit data accesses
//   bus_state          : mem_bus_ctrl FSM states
//   bus_owner          : which requester currently owns the memory port
//   addr_from_source   : data-address select mux
package cu_pkg;

   typedef enum logic [1:0] {
      value_from_pc       = 2'b00,
      value_from_reg_file = 2'b01,
      value_from_imm      = 2'b10
   } mem_req_source_sel;

   // 2'b11 is not a legal source; the controller reports it as a bus error.
   localparam logic [1:0] SRC_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      bus_idle,
      bus_access,
      bus_complete
   } bus_state;

   typedef enum logic {
      owner_fetch,
      owner_data
   } bus_owner;

   // Widest address the select mux handles; callers zero-extend into it and
   // truncate the result back to their own address width.
   localparam int unsigned ADDR_MAX_W = 32;

   function automatic logic [ADDR_MAX_W-1:0] addr_from_source(
      input logic [1:0]            src,
      input logic [ADDR_MAX_W-1:0] pc,
      input logic [ADDR_MAX_W-1:0] reg_a,
      input logic [ADDR_MAX_W-1:0] imm
   );
      logic [ADDR_MAX_W-1:0] sel;
      sel = '0;
      case (src)
         value_from_pc:       sel = pc;
         value_from_reg_file: sel = reg_a;
         value_from_imm:      sel = imm;
         default:             sel = '0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbiter and bus controller between instruction fetch and the
// decode unit's data-access path, driving a single byte-wide memory port.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   fetch_req, pc_addr  fetch request (level) and PC address
//   data_req, data_we   data request (level) and direction (1 = write)
//   data_src            data address source (cu_pkg::mem_req_source_sel encoding)
//   reg_addr, imm_addr  register-file and immediate data addresses
//   data_wdata          data write value
//   rdata               latched read data, valid with *_done
//   fetch_done          one-cycle fetch completion pulse
//   data_done           one-cycle data completion pulse
//   bus_err             one-cycle pulse: wait timeout or illegal data_src
//   busy                access in flight
//   mem_addr, mem_wdata registered external address / write data
//   mem_re, mem_we      external read / write strobes (mutually exclusive)
//   mem_ready           external access complete
//   mem_rdata           external read data
module mem_bus_ctrl
   import cu_pkg::*;
#(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [1:0]        data_src,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [ADDR_W-1:0] imm_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              fetch_done,
   output logic              data_done,
   output logic              bus_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   bus_state          state;
   bus_owner          owner;
   bus_owner          last_grant;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] data_addr;
   logic              grant_fetch;
   logic              grant_data;

   assign data_addr = ADDR_W'(addr_from_source(data_src,
                                                ADDR_MAX_W'(pc_addr),
                                                ADDR_MAX_W'(reg_addr),
                                                ADDR_MAX_W'(imm_addr)));

   // With both requests pending, the side not served last wins.
   assign grant_fetch = fetch_req && (!data_req || (last_grant == owner_data));
   assign grant_data  = data_req && !grant_fetch;

   assign busy = (state != bus_idle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= bus_idle;
         owner      <= owner_fetch;
         last_grant <= owner_data;
         wait_cnt   <= '0;
         rdata      <= '0;
         fetch_done <= 1'b0;
         data_done  <= 1'b0;
         bus_err    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         data_done  <= 1'b0;
         bus_err    <= 1'b0;
         case (state)
            bus_idle: begin
               if (grant_fetch) begin
                  owner      <= owner_fetch;
                  last_grant <= owner_fetch;
                  mem_addr   <= pc_addr;
                  mem_re     <= 1'b1;
                  mem_we     <= 1'b0;
                  wait_cnt   <= '0;
                  state      <= bus_access;
               end else if (grant_data) begin
                  last_grant <= owner_data;
                  if (data_src == SRC_ILLEGAL) begin
                     bus_err <= 1'b1;
                  end else begin
                     owner     <= owner_data;
                     mem_addr  <= data_addr;
                     mem_wdata <= data_wdata;
                     mem_re    <= !data_we;
                     mem_we    <= data_we;
                     wait_cnt  <= '0;
                     state     <= bus_access;
                  end
               end
            end
            bus_access: begin
               if (mem_ready) begin
                  if (mem_re) begin
                     rdata <= mem_rdata;
                  end
                  mem_re   <= 1'b0;
                  mem_we   <= 1'b0;
                  wait_cnt <= '0;
                  state    <= bus_complete;
                  // Done is raised here so it is visible during COMPLETE.
                  if (owner == owner_fetch) begin
                     fetch_done <= 1'b1;
                  end else begin
                     data_done <= 1'b1;
                  end
               end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                  mem_re   <= 1'b0;
                  mem_we   <= 1'b0;
                  bus_err  <= 1'b1;
                  wait_cnt <= '0;
                  state    <= bus_idle;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            bus_complete: begin
               wait_cnt <= '0;
               state    <= bus_idle;
            end
            default: begin
               mem_re   <= 1'b0;
               mem_we   <= 1'b0;
               wait_cnt <= '0;
               state    <= bus_idle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed scoreboard bench for mem_bus_ctrl.
// A memory responder checks each bus access against the expected-access queue;
// a monitor checks each completion/error pulse against the expected-response queue.
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [15:0] pc_addr = '0;
   logic        data_req = 1'b0;
   logic        data_we = 1'b0;
   logic [1:0]  data_src = 2'b00;
   logic [15:0] reg_addr = '0;
   logic [15:0] imm_addr = '0;
   logic [7:0]  data_wdata = '0;
   logic [7:0]  rdata;
   logic        fetch_done, data_done, bus_err, busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_re, mem_we;
   logic        mem_ready = 1'b0;
   logic [7:0]  mem_rdata = '0;

   mem_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .pc_addr(pc_addr),
      .data_req(data_req), .data_we(data_we), .data_src(data_src),
      .reg_addr(reg_addr), .imm_addr(imm_addr), .data_wdata(data_wdata),
      .rdata(rdata), .fetch_done(fetch_done), .data_done(data_done),
      .bus_err(bus_err), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_we(mem_we),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
      int          len;
   } acc_t;

   typedef struct {
      logic [2:0] kind;   // {bus_err, data_done, fetch_done}
      logic [7:0] rdata;
      logic       prev_strobe;
   } rsp_t;

   localparam logic [2:0] K_FETCH = 3'b001;
   localparam logic [2:0] K_DATA  = 3'b010;
   localparam logic [2:0] K_ERR   = 3'b100;

   acc_t exp_acc[$];
   rsp_t exp_rsp[$];

   int checks = 0;
   int errors = 0;

   // responder configuration
   int         cfg_wait = 0;
   logic       cfg_stuck = 1'b0;
   logic [7:0] cfg_xor = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder
   int          strobe_cyc = 0;
   logic [15:0] cur_addr;
   logic        cur_we;
   logic [7:0]  cur_wdata;
   logic        stable_ok;

   always @(negedge clk) begin
      if (mem_re || mem_we) begin
         check("strobe_exclusive", {31'd0, mem_re && mem_we}, 32'd0);
         if (strobe_cyc == 0) begin
            cur_addr  = mem_addr;
            cur_we    = mem_we;
            cur_wdata = mem_wdata;
            stable_ok = 1'b1;
         end else if (mem_addr !== cur_addr || mem_we !== cur_we ||
                      (cur_we && mem_wdata !== cur_wdata)) begin
            stable_ok = 1'b0;
         end
         strobe_cyc++;
         mem_ready = !cfg_stuck && (strobe_cyc == cfg_wait + 1);
         mem_rdata = mem_addr[7:0] ^ cfg_xor;
      end else begin
         if (strobe_cyc != 0) begin
            if (exp_acc.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_access: addr %0h we %0b len %0d", cur_addr, cur_we, strobe_cyc);
            end else begin
               acc_t a;
               a = exp_acc.pop_front();
               check("acc_addr", {16'd0, cur_addr}, {16'd0, a.addr});
               check("acc_we", {31'd0, cur_we}, {31'd0, a.we});
               if (a.we) check("acc_wdata", {24'd0, cur_wdata}, {24'd0, a.wdata});
               check("acc_len", strobe_cyc, a.len);
               check("acc_stable", {31'd0, stable_ok}, 32'd1);
            end
         end
         strobe_cyc = 0;
         mem_ready  = 1'b0;
      end
   end

   // Response monitor
   logic prev_strobe = 1'b0;

   always @(posedge clk) begin
      #1;
      if (fetch_done || data_done || bus_err) begin
         if (exp_rsp.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: got {err,dd,fd}=%b", {bus_err, data_done, fetch_done});
         end else begin
            rsp_t r;
            r = exp_rsp.pop_front();
            check("rsp_kind", {29'd0, bus_err, data_done, fetch_done}, {29'd0, r.kind});
            check("rsp_rdata", {24'd0, rdata}, {24'd0, r.rdata});
            check("rsp_prev_strobe", {31'd0, prev_strobe}, {31'd0, r.prev_strobe});
         end
      end
      prev_strobe = mem_re || mem_we;
   end

   task automatic wait_pulse(input int which, input int limit, output int n);
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < limit) begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = fetch_done;
            1:       hit = data_done;
            default: hit = bus_err;
         endcase
      end
      if (!hit) begin
         checks++; errors++;
         $display("FAIL wait_pulse_%0d: no pulse within %0d cycles", which, limit);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int dones;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rdata", {24'd0, rdata}, 32'd0);
      check("rst_pulses", {29'd0, bus_err, data_done, fetch_done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
      check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Both requesters held: fetch first (last_grant=DATA), then alternate.
      cfg_wait = 0; cfg_stuck = 1'b0; cfg_xor = 8'h00;
      pc_addr = 16'h1234; reg_addr = 16'h2078; data_src = 2'b01; data_we = 1'b0;
      exp_acc.push_back('{16'h1234, 1'b0, 8'h00, 1});
      exp_acc.push_back('{16'h2078, 1'b0, 8'h00, 1});
      exp_acc.push_back('{16'h1234, 1'b0, 8'h00, 1});
      exp_acc.push_back('{16'h2078, 1'b0, 8'h00, 1});
      exp_rsp.push_back('{K_FETCH, 8'h34, 1'b1});
      exp_rsp.push_back('{K_DATA,  8'h78, 1'b1});
      exp_rsp.push_back('{K_FETCH, 8'h34, 1'b1});
      exp_rsp.push_back('{K_DATA,  8'h78, 1'b1});
      fetch_req = 1'b1; data_req = 1'b1;
      dones = 0; n = 0;
      while (dones < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (fetch_done || data_done) dones++;
      end
      fetch_req = 1'b0; data_req = 1'b0;
      check("alt_dones", dones, 4);
      check("alt_cycles", n, 11);
      repeat (2) @(negedge clk);

      // Fetch only, zero wait states.
      cfg_xor = 8'h3E; pc_addr = 16'h0100;
      exp_acc.push_back('{16'h0100, 1'b0, 8'h00, 1});
      exp_rsp.push_back('{K_FETCH, 8'h3E, 1'b1});
      fetch_req = 1'b1;
      wait_pulse(0, 20, n);
      fetch_req = 1'b0;
      check("fetch_latency", n, 2);
      repeat (2) @(negedge clk);

      // Data write via register file, three wait states; rdata unchanged.
      cfg_wait = 3; data_src = 2'b01; reg_addr = 16'hC000; data_wdata = 8'h55; data_we = 1'b1;
      exp_acc.push_back('{16'hC000, 1'b1, 8'h55, 4});
      exp_rsp.push_back('{K_DATA, 8'h3E, 1'b1});
      data_req = 1'b1;
      wait_pulse(1, 20, n);
      data_req = 1'b0;
      check("write_latency", n, 5);
      repeat (2) @(negedge clk);

      // Timeout: strobe held MAX_WAIT+1 cycles, then bus_err, no done.
      cfg_stuck = 1'b1; cfg_wait = 0; pc_addr = 16'h0200;
      exp_acc.push_back('{16'h0200, 1'b0, 8'h00, 16});
      exp_rsp.push_back('{K_ERR, 8'h3E, 1'b1});
      fetch_req = 1'b1;
      wait_pulse(2, 40, n);
      fetch_req = 1'b0;
      check("timeout_latency", n, 17);
      cfg_stuck = 1'b0;
      repeat (2) @(negedge clk);

      // Next request serviced normally: immediate-address read.
      cfg_xor = 8'h5A; data_src = 2'b10; imm_addr = 16'h8000; data_we = 1'b0;
      exp_acc.push_back('{16'h8000, 1'b0, 8'h00, 1});
      exp_rsp.push_back('{K_DATA, 8'h5A, 1'b1});
      data_req = 1'b1;
      wait_pulse(1, 20, n);
      data_req = 1'b0;
      check("imm_latency", n, 2);
      repeat (2) @(negedge clk);

      // Illegal source: no bus access, bus_err one cycle later.
      data_src = 2'b11;
      exp_rsp.push_back('{K_ERR, 8'h5A, 1'b0});
      data_req = 1'b1;
      wait_pulse(2, 10, n);
      data_req = 1'b0;
      check("illegal_latency", n, 1);
      check("illegal_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);

      // Reset mid-access: strobes and busy drop at once, no pulse afterwards.
      cfg_stuck = 1'b1; pc_addr = 16'h0300;
      exp_acc.push_back('{16'h0300, 1'b0, 8'h00, 2});
      fetch_req = 1'b1;
      repeat (2) @(negedge clk);
      check("pre_rst_re", {31'd0, mem_re}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_re", {31'd0, mem_re}, 32'd0);
      check("async_rst_we", {31'd0, mem_we}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_rdata", {24'd0, rdata}, 32'd0);
      fetch_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cfg_stuck = 1'b0;
      repeat (10) @(negedge clk);

      check("acc_queue_empty", exp_acc.size(), 0);
      check("rsp_queue_empty", exp_rsp.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
